// File: rtl/i2s_tx_pkg.sv
// Shared definitions for the I2S / left-justified / TDM serial-audio transmitter.
package i2s_tx_pkg;

    // Framing mode encodings
    localparam int MODE_I2S = 0;
    localparam int MODE_LJ  = 1;
    localparam int MODE_TDM = 2;

    // Widest sample the FIFO word can carry
    localparam int MAX_SAMPLE_WIDTH = 32;

    // One FIFO entry: frame marker plus the (zero-extended) sample
    typedef struct packed {
        logic                        tlast;
        logic [MAX_SAMPLE_WIDTH-1:0] sample;
    } fifo_word_t;

    // Elaboration-time legality check of the transmitter parameter set
    function automatic bit params_ok(
        input int tdata_width,
        input int sample_width,
        input int slot_width,
        input int num_channels,
        input int mode,
        input int fifo_depth,
        input int bclk_div
    );
        bit ok;
        ok = 1'b1;
        if (sample_width < 8 || sample_width > slot_width)           ok = 1'b0;
        if (slot_width > MAX_SAMPLE_WIDTH)                            ok = 1'b0;
        if (sample_width > tdata_width)                               ok = 1'b0;
        if (num_channels < 2 || num_channels > 8)                     ok = 1'b0;
        if (mode < MODE_I2S || mode > MODE_TDM)                       ok = 1'b0;
        if (mode != MODE_TDM && num_channels != 2)                    ok = 1'b0;
        if (fifo_depth < 2 || (fifo_depth & (fifo_depth - 1)) != 0)   ok = 1'b0;
        if (bclk_div < 2)                                             ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/i2s_tx_fifo.sv
// First-word-fall-through FIFO holding {tlast, sample} words for the transmitter.
module i2s_tx_fifo
    import i2s_tx_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  fifo_word_t               push_word,
    input  logic                     pop,
    output fifo_word_t               head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    fifo_word_t     mem [DEPTH];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic           do_push;
    logic           do_pop;

    // A pop frees a slot in the same cycle, so a full FIFO can still accept a push alongside it
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign level = wr_ptr - rd_ptr;
    assign empty = (level == '0);
    assign full  = (level == (AW+1)'(DEPTH));
    assign head  = mem[rd_ptr[AW-1:0]];

    // Read/write pointers, one extra wrap bit to tell full from empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage array, no reset needed since entries are only read once written
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_word;
    end

endmodule

// File: rtl/i2s_tdm_tx.sv
// Serial-audio transmitter: AXI4-Stream samples in, I2S / left-justified / TDM out.
// bclk, frame sync and data are all derived from s00_axis_aclk.
module i2s_tdm_tx
    import i2s_tx_pkg::*;
#(
    parameter int C_S00_AXIS_TDATA_WIDTH = 32,
    parameter int SAMPLE_WIDTH           = 24,
    parameter int SLOT_WIDTH             = 32,
    parameter int NUM_CHANNELS           = 2,
    parameter int MODE                   = 0,
    parameter int FIFO_DEPTH             = 8,
    parameter int BCLK_DIV               = 4
) (
    input  logic                                s00_axis_aclk,
    input  logic                                s00_axis_areset,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
    input  logic                                s00_axis_tvalid,
    output logic                                s00_axis_tready,
    input  logic                                s00_axis_tlast,
    output logic                                bclk,
    output logic                                lrclk,
    output logic                                sdata,
    output logic                                underrun,
    output logic                                frame_err,
    output logic [$clog2(FIFO_DEPTH):0]         fifo_level
);

    localparam int DIV_W  = $clog2(BCLK_DIV);
    localparam int BIT_W  = $clog2(SLOT_WIDTH);
    localparam int SLOT_W = $clog2(NUM_CHANNELS);

    if (!params_ok(C_S00_AXIS_TDATA_WIDTH, SAMPLE_WIDTH, SLOT_WIDTH,
                   NUM_CHANNELS, MODE, FIFO_DEPTH, BCLK_DIV)) begin : g_param_check
        $error("i2s_tdm_tx: illegal parameter combination");
    end

    logic                   clk;
    logic                   rst;

    // Bit clock divider
    logic [DIV_W-1:0]       div_cnt;
    logic                   div_tick;
    logic                   bclk_q;
    logic                   bclk_fall;

    // Position of the bit being driven at the next bclk fall
    logic [BIT_W-1:0]       bit_cnt;
    logic [SLOT_W-1:0]      slot_cnt;
    logic                   slot_start;
    logic                   last_bit;
    logic                   last_slot;

    // FIFO interface
    logic                   ready_en;
    logic                   fifo_push;
    logic                   fifo_pop;
    fifo_word_t             fifo_in;
    fifo_word_t             fifo_head;
    logic                   fifo_full;
    logic                   fifo_empty;

    // Serialiser
    logic [SLOT_WIDTH-1:0]  load_word;
    logic [SLOT_WIDTH-1:0]  shreg;
    logic                   cur_bit;
    logic                   dly_q;
    logic                   sdata_q;
    logic                   lrclk_q;

    // Status
    logic                   started;
    logic                   underrun_q;
    logic                   frame_err_q;

    // Only the low SAMPLE_WIDTH bits of the stream and of the stored word are used
    logic                   unused_bits;
    assign unused_bits = ^{s00_axis_tdata, fifo_head.sample};

    assign clk = s00_axis_aclk;
    assign rst = s00_axis_areset;

    assign div_tick   = (div_cnt == DIV_W'(BCLK_DIV - 1));
    assign bclk_fall  = div_tick && bclk_q;
    assign slot_start = (bit_cnt == '0);
    assign last_bit   = (bit_cnt == BIT_W'(SLOT_WIDTH - 1));
    assign last_slot  = (slot_cnt == SLOT_W'(NUM_CHANNELS - 1));

    assign s00_axis_tready = ready_en && !fifo_full;
    assign fifo_push       = s00_axis_tvalid && s00_axis_tready;
    assign fifo_pop        = bclk_fall && slot_start && !fifo_empty;

    // Divider: bclk toggles every BCLK_DIV aclk cycles, free-running from reset release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            bclk_q  <= 1'b0;
        end else if (div_tick) begin
            div_cnt <= '0;
            bclk_q  <= ~bclk_q;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Bit and slot counters advance after each bit is driven on a bclk fall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt  <= '0;
            slot_cnt <= '0;
        end else if (bclk_fall) begin
            if (last_bit) begin
                bit_cnt  <= '0;
                slot_cnt <= last_slot ? '0 : slot_cnt + SLOT_W'(1);
            end else begin
                bit_cnt <= bit_cnt + BIT_W'(1);
            end
        end
    end

    // tready is held low until the first clock edge after reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ready_en <= 1'b0;
        else     ready_en <= 1'b1;
    end

    // Build the FIFO entry from the stream beat
    always_comb begin
        fifo_in                            = '0;
        fifo_in.tlast                      = s00_axis_tlast;
        fifo_in.sample[SAMPLE_WIDTH-1:0]   = s00_axis_tdata[SAMPLE_WIDTH-1:0];
    end

    i2s_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_word (fifo_in),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // Slot image of the FIFO head: sample MSB-aligned, zero-padded below
    always_comb begin
        load_word                                   = '0;
        load_word[SLOT_WIDTH-1 -: SAMPLE_WIDTH]     = fifo_head.sample[SAMPLE_WIDTH-1:0];
    end

    // At a slot boundary the MSB comes straight from the FIFO head so it leaves on the same fall
    always_comb begin
        cur_bit = shreg[SLOT_WIDTH-1];
        if (slot_start) cur_bit = fifo_empty ? 1'b0 : load_word[SLOT_WIDTH-1];
    end

    // Shift register: loaded (minus its MSB) at slot start, shifted on every other fall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg <= '0;
        end else if (bclk_fall) begin
            if (slot_start) shreg <= fifo_empty ? '0 : (load_word << 1);
            else            shreg <= shreg << 1;
        end
    end

    // Registered serial outputs; I2S data lags the word select by one bclk via dly_q
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dly_q   <= 1'b0;
            sdata_q <= 1'b0;
            lrclk_q <= 1'b0;
        end else if (bclk_fall) begin
            dly_q   <= cur_bit;
            sdata_q <= (MODE == MODE_I2S) ? dly_q : cur_bit;
            if (MODE == MODE_TDM) lrclk_q <= (slot_cnt == '0) && slot_start;
            else                  lrclk_q <= (slot_cnt == SLOT_W'(1));
        end
    end

    // Underrun and framing error pulses, evaluated at each slot load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            started     <= 1'b0;
            underrun_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            underrun_q  <= 1'b0;
            frame_err_q <= 1'b0;
            if (bclk_fall && slot_start) begin
                if (!fifo_empty) begin
                    started <= 1'b1;
                    if (fifo_head.tlast != last_slot) frame_err_q <= 1'b1;
                end else if (started) begin
                    underrun_q <= 1'b1;
                end
            end
        end
    end

    assign bclk      = bclk_q;
    assign lrclk     = lrclk_q;
    assign sdata     = sdata_q;
    assign underrun  = underrun_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_i2s_tdm_tx.sv
// Directed bench for i2s_tdm_tx: I2S, left-justified and TDM instances run side by side
// from one clock; serial bits are captured on every bclk rise and compared with
// hand-computed slot words.
module tb_i2s_tdm_tx;
    import i2s_tx_pkg::*;

    logic        clk;
    logic        rst;

    // Stream shared by the I2S (dut0) and left-justified (dut1) instances
    logic [31:0] tdata_a;
    logic        tvalid_a;
    logic        tlast_a;
    // Stream for the TDM instance (dut2)
    logic [31:0] tdata_t;
    logic        tvalid_t;
    logic        tlast_t;

    logic        tready0, bclk0, lrclk0, sdata0, ur0, fe0;
    logic        tready1, bclk1, lrclk1, sdata1, ur1, fe1;
    logic        tready2, bclk2, lrclk2, sdata2, ur2, fe2;
    logic [3:0]  lvl0, lvl1, lvl2;

    int checks = 0;
    int errors = 0;
    int cyc;

    // Capture state, indexed by bclk rise number since reset release
    logic [1023:0] sd0, sd1, sd2, lr0, lr1, lr2;
    int  ridx;
    int  rc0, rc1;
    logic prev_b;
    int  ucnt0, ucnt1, ucnt2, fcnt0, fcnt1, fcnt2;

    logic [23:0] bp_words [9];

    i2s_tdm_tx #(
        .MODE (MODE_I2S)
    ) dut0 (
        .s00_axis_aclk   (clk),
        .s00_axis_areset (rst),
        .s00_axis_tdata  (tdata_a),
        .s00_axis_tvalid (tvalid_a),
        .s00_axis_tready (tready0),
        .s00_axis_tlast  (tlast_a),
        .bclk            (bclk0),
        .lrclk           (lrclk0),
        .sdata           (sdata0),
        .underrun        (ur0),
        .frame_err       (fe0),
        .fifo_level      (lvl0)
    );

    i2s_tdm_tx #(
        .MODE (MODE_LJ)
    ) dut1 (
        .s00_axis_aclk   (clk),
        .s00_axis_areset (rst),
        .s00_axis_tdata  (tdata_a),
        .s00_axis_tvalid (tvalid_a),
        .s00_axis_tready (tready1),
        .s00_axis_tlast  (tlast_a),
        .bclk            (bclk1),
        .lrclk           (lrclk1),
        .sdata           (sdata1),
        .underrun        (ur1),
        .frame_err       (fe1),
        .fifo_level      (lvl1)
    );

    i2s_tdm_tx #(
        .MODE         (MODE_TDM),
        .NUM_CHANNELS (4),
        .SLOT_WIDTH   (16),
        .SAMPLE_WIDTH (16)
    ) dut2 (
        .s00_axis_aclk   (clk),
        .s00_axis_areset (rst),
        .s00_axis_tdata  (tdata_t),
        .s00_axis_tvalid (tvalid_t),
        .s00_axis_tready (tready2),
        .s00_axis_tlast  (tlast_t),
        .bclk            (bclk2),
        .lrclk           (lrclk2),
        .sdata           (sdata2),
        .underrun        (ur2),
        .frame_err       (fe2),
        .fifo_level      (lvl2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Sample on the falling aclk edge: record bits at each bclk rise, count pulses
    always @(negedge clk) begin
        if (rst) begin
            ridx = 0; prev_b = 1'b0; rc0 = 0; rc1 = 0;
            ucnt0 = 0; ucnt1 = 0; ucnt2 = 0;
            fcnt0 = 0; fcnt1 = 0; fcnt2 = 0;
            sd0 = '0; sd1 = '0; sd2 = '0; lr0 = '0; lr1 = '0; lr2 = '0;
        end else begin
            if (bclk0 && !prev_b) begin
                if (ridx == 0) rc0 = cyc;
                if (ridx == 1) rc1 = cyc;
                if (ridx < 1024) begin
                    sd0[ridx] = sdata0; lr0[ridx] = lrclk0;
                    sd1[ridx] = sdata1; lr1[ridx] = lrclk1;
                    sd2[ridx] = sdata2; lr2[ridx] = lrclk2;
                end
                ridx++;
            end
            prev_b = bclk0;
            if (ur0) ucnt0++;
            if (ur1) ucnt1++;
            if (ur2) ucnt2++;
            if (fe0) fcnt0++;
            if (fe1) fcnt1++;
            if (fe2) fcnt2++;
        end
    end

    // Assemble len captured bits, first capture becomes the MSB
    function automatic logic [31:0] get_bits(input logic [1023:0] v, input int start, input int len);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < len; i++) r = {r[30:0], v[start + i]};
        return r;
    endfunction

    task automatic wait_cyc(input int target);
        int g = 0;
        while (cyc < target && g < 20000) begin
            @(negedge clk);
            g++;
        end
        if (cyc < target) begin
            checks++; errors++;
            $display("FAIL wait_cyc timeout got cyc=%0d want %0d", cyc, target);
        end
    endtask

    task automatic push_a(input logic [31:0] d, input logic l);
        int w = 0;
        tdata_a = d; tlast_a = l; tvalid_a = 1'b1;
        while (!tready0 && w < 400) begin
            @(negedge clk);
            w++;
        end
        if (!tready0) begin
            checks++; errors++;
            $display("FAIL push_a tready timeout got 0 want 1");
        end
        @(posedge clk); #1;
        tvalid_a = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tvalid_a = 0; tdata_a = '0; tlast_a = 0;
        tvalid_t = 0; tdata_t = '0; tlast_t = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bclk0, lrclk0, sdata0, tready0, ur0, fe0} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs0 got %b want 000000", {bclk0, lrclk0, sdata0, tready0, ur0, fe0});
        end
        checks++;
        if ({bclk2, lrclk2, sdata2, tready2, ur2, fe2} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs2 got %b want 000000", {bclk2, lrclk2, sdata2, tready2, ur2, fe2});
        end
        checks++;
        if (lvl0 !== 4'd0) begin
            errors++;
            $display("FAIL reset_level got %0d want 0", lvl0);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (tready0 !== 1'b1 || tready2 !== 1'b1) begin
            errors++;
            $display("FAIL tready_after_release got %b%b want 11", tready0, tready2);
        end
    endtask

    // Push two stereo frames to dut0/dut1 and five TDM words to dut2 before the first bclk fall
    task automatic test_stream_fill;
        logic [31:0] tdm_words [5];
        tdm_words[0] = 32'hFFFF1111; tdm_words[1] = 32'h00002222; tdm_words[2] = 32'h12343333;
        tdm_words[3] = 32'h00004444; tdm_words[4] = 32'h00005555;
        for (int i = 0; i < 5; i++) begin
            tvalid_a = (i < 4);
            tdata_a  = (i % 2 == 1) ? 32'hA5A58001 : 32'hAA558001;
            tlast_a  = (i % 2 == 1);
            tvalid_t = 1'b1;
            tdata_t  = tdm_words[i];
            tlast_t  = (i >= 3);
            checks++;
            if (tready0 !== 1'b1 || tready2 !== 1'b1) begin
                errors++;
                $display("FAIL fill_ready[%0d] got %b%b want 11", i, tready0, tready2);
            end
            @(posedge clk); #1;
        end
        tvalid_a = 0; tvalid_t = 0;
        checks++;
        if (lvl0 !== 4'd4 || lvl2 !== 4'd5) begin
            errors++;
            $display("FAIL fill_level got %0d/%0d want 4/5", lvl0, lvl2);
        end
    endtask

    task automatic test_i2s;
        logic [31:0] exp_w [4];
        exp_w[0] = 32'h55800100; exp_w[1] = 32'hA5800100;
        exp_w[2] = 32'h55800100; exp_w[3] = 32'hA5800100;
        wait_cyc(1560);
        checks++;
        if (rc0 !== 4) begin
            errors++;
            $display("FAIL first_bclk_rise got %0d want 4", rc0);
        end
        checks++;
        if (rc1 - rc0 !== 8) begin
            errors++;
            $display("FAIL bclk_period got %0d want 8", rc1 - rc0);
        end
        // I2S: slot bit b of position q is seen at rise q+2
        for (int s = 0; s < 4; s++) begin
            checks++;
            if (get_bits(sd0, s * 32 + 2, 32) !== exp_w[s]) begin
                errors++;
                $display("FAIL i2s_slot[%0d] got %h want %h", s, get_bits(sd0, s * 32 + 2, 32), exp_w[s]);
            end
        end
        for (int s = 4; s < 6; s++) begin
            checks++;
            if (get_bits(sd0, s * 32 + 2, 32) !== 32'h0) begin
                errors++;
                $display("FAIL i2s_starve_slot[%0d] got %h want 00000000", s, get_bits(sd0, s * 32 + 2, 32));
            end
        end
        checks++;
        if (get_bits(lr0, 1, 32) !== 32'h0 || get_bits(lr0, 33, 32) !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL i2s_lrclk got %h_%h want 00000000_ffffffff", get_bits(lr0, 1, 32), get_bits(lr0, 33, 32));
        end
        checks++;
        if (ucnt0 !== 3) begin
            errors++;
            $display("FAIL i2s_underrun_count got %0d want 3", ucnt0);
        end
        checks++;
        if (fcnt0 !== 0) begin
            errors++;
            $display("FAIL i2s_frame_err_count got %0d want 0", fcnt0);
        end
    endtask

    task automatic test_lj;
        logic [31:0] exp_w [4];
        exp_w[0] = 32'h55800100; exp_w[1] = 32'hA5800100;
        exp_w[2] = 32'h55800100; exp_w[3] = 32'hA5800100;
        // Left-justified: position q is seen at rise q+1, aligned with lrclk
        for (int s = 0; s < 4; s++) begin
            checks++;
            if (get_bits(sd1, s * 32 + 1, 32) !== exp_w[s]) begin
                errors++;
                $display("FAIL lj_slot[%0d] got %h want %h", s, get_bits(sd1, s * 32 + 1, 32), exp_w[s]);
            end
        end
        checks++;
        if (get_bits(lr1, 1, 32) !== 32'h0 || get_bits(lr1, 33, 32) !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL lj_lrclk got %h_%h want 00000000_ffffffff", get_bits(lr1, 1, 32), get_bits(lr1, 33, 32));
        end
        checks++;
        if (ucnt1 !== 3 || fcnt1 !== 0) begin
            errors++;
            $display("FAIL lj_pulses got ur=%0d fe=%0d want ur=3 fe=0", ucnt1, fcnt1);
        end
    endtask

    task automatic test_tdm;
        logic [15:0] exp_w [6];
        int highs;
        exp_w[0] = 16'h1111; exp_w[1] = 16'h2222; exp_w[2] = 16'h3333;
        exp_w[3] = 16'h4444; exp_w[4] = 16'h5555; exp_w[5] = 16'h0000;
        for (int s = 0; s < 6; s++) begin
            checks++;
            if (get_bits(sd2, s * 16 + 1, 16) !== {16'h0, exp_w[s]}) begin
                errors++;
                $display("FAIL tdm_slot[%0d] got %h want %h", s, get_bits(sd2, s * 16 + 1, 16), exp_w[s]);
            end
        end
        highs = 0;
        for (int n = 1; n <= 192; n++) if (lr2[n]) highs++;
        checks++;
        if (highs !== 3 || lr2[1] !== 1'b1 || lr2[65] !== 1'b1 || lr2[129] !== 1'b1) begin
            errors++;
            $display("FAIL tdm_frame_sync got highs=%0d r1=%b r65=%b r129=%b want 3 1 1 1",
                     highs, lr2[1], lr2[65], lr2[129]);
        end
        checks++;
        if (fcnt2 !== 1) begin
            errors++;
            $display("FAIL tdm_frame_err_count got %0d want 1", fcnt2);
        end
        checks++;
        if (ucnt2 !== 8) begin
            errors++;
            $display("FAIL tdm_underrun_count got %0d want 8", ucnt2);
        end
    endtask

    task automatic test_back_pressure;
        bp_words[0] = 24'h800001; bp_words[1] = 24'h7FFFFE; bp_words[2] = 24'h123456;
        bp_words[3] = 24'hABCDEF; bp_words[4] = 24'h0F0F0F; bp_words[5] = 24'hF0F0F0;
        bp_words[6] = 24'h000100; bp_words[7] = 24'hFFFFFF; bp_words[8] = 24'h5A5A5A;
        // Start mid slot 1 of frame 3 so the first pop lands on slot 0 of frame 4
        wait_cyc(1956);
        for (int i = 0; i < 8; i++) push_a({8'hC3, bp_words[i]}, (i % 2 == 1));
        checks++;
        if (tready0 !== 1'b0 || tready1 !== 1'b0) begin
            errors++;
            $display("FAIL full_tready got %b%b want 00", tready0, tready1);
        end
        checks++;
        if (lvl0 !== 4'd8) begin
            errors++;
            $display("FAIL full_level got %0d want 8", lvl0);
        end
        push_a({8'hC3, bp_words[8]}, 1'b0);
        wait_cyc(4380);
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (get_bits(sd1, 256 + 32 * i + 1, 32) !== {bp_words[i], 8'h00}) begin
                errors++;
                $display("FAIL bp_lj_word[%0d] got %h want %h", i, get_bits(sd1, 256 + 32 * i + 1, 32), {bp_words[i], 8'h00});
            end
            checks++;
            if (get_bits(sd0, 256 + 32 * i + 2, 32) !== {bp_words[i], 8'h00}) begin
                errors++;
                $display("FAIL bp_i2s_word[%0d] got %h want %h", i, get_bits(sd0, 256 + 32 * i + 2, 32), {bp_words[i], 8'h00});
            end
        end
        checks++;
        if (fcnt0 !== 0 || fcnt1 !== 0) begin
            errors++;
            $display("FAIL bp_frame_err got %0d/%0d want 0/0", fcnt0, fcnt1);
        end
    endtask

    task automatic test_reset_mid;
        int g = 0;
        int ones = 0;
        push_a(32'h00FFFFFF, 1'b0);
        push_a(32'h00FFFFFF, 1'b1);
        push_a(32'h00FFFFFF, 1'b0);
        while (!bclk0 && g < 50) begin
            @(negedge clk);
            g++;
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bclk0, lrclk0, sdata0, tready0, ur0, fe0} !== 6'b0 || lvl0 !== 4'd0) begin
            errors++;
            $display("FAIL mid_reset0 got %b lvl=%0d want 000000 lvl=0", {bclk0, lrclk0, sdata0, tready0, ur0, fe0}, lvl0);
        end
        checks++;
        if ({bclk2, lrclk2, sdata2, tready2, ur2, fe2} !== 6'b0 || lvl2 !== 4'd0) begin
            errors++;
            $display("FAIL mid_reset2 got %b lvl=%0d want 000000 lvl=0", {bclk2, lrclk2, sdata2, tready2, ur2, fe2}, lvl2);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_cyc(1060);
        for (int n = 0; n < 130; n++) if (sd0[n] || sd1[n] || sd2[n]) ones++;
        checks++;
        if (ones !== 0) begin
            errors++;
            $display("FAIL post_reset_data got %0d ones want 0", ones);
        end
        checks++;
        if (ucnt0 !== 0 || ucnt1 !== 0 || ucnt2 !== 0) begin
            errors++;
            $display("FAIL post_reset_underrun got %0d/%0d/%0d want 0/0/0", ucnt0, ucnt1, ucnt2);
        end
        checks++;
        if (lvl0 !== 4'd0 || tready0 !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_fifo got lvl=%0d rdy=%b want lvl=0 rdy=1", lvl0, tready0);
        end
    endtask

    initial begin
        test_reset;
        test_stream_fill;
        test_i2s;
        test_lj;
        test_tdm;
        test_back_pressure;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
